// File: rtl/biu_constants_pkg.sv
// Bus interface unit encodings shared by the cache stages: transfer size,
// burst type (including the wrapping burst lengths) and protection bits.
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HWORD = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011,
    QWORD = 3'b100
  } biu_size_t;

  typedef enum logic [3:0] {
    SINGLE = 4'd0,
    INCR   = 4'd1,
    WRAP4  = 4'd2,
    INCR4  = 4'd3,
    WRAP8  = 4'd4,
    INCR8  = 4'd5,
    WRAP16 = 4'd6,
    INCR16 = 4'd7,
    WRAP2  = 4'd8
  } biu_type_t;

  typedef logic [2:0] biu_prot_t;

  localparam biu_prot_t PROT_DATA       = 3'b000;
  localparam biu_prot_t PROT_PRIVILEGED = 3'b001;
  localparam biu_prot_t PROT_NONSECURE  = 3'b010;
  localparam biu_prot_t PROT_INSTR      = 3'b100;

  // Wrapping burst type that covers exactly one cacheline of 'beats' words
  function automatic biu_type_t biu_wrap_type(input int beats);
    case (beats)
      2:       return WRAP2;
      4:       return WRAP4;
      8:       return WRAP8;
      16:      return WRAP16;
      default: return SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/riscv_cache_pkg.sv
// Cache hit-stage state encoding and cacheline geometry helpers.
package riscv_cache_pkg;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_FILL    = 2'd1,
    ST_SINGLE  = 2'd2,
    ST_RECOVER = 2'd3
  } cache_state_t;

  // Number of data words per cacheline
  function automatic int cache_beats(input int blk_bits, input int xlen);
    return blk_bits / xlen;
  endfunction

  // Byte-offset width of a data word
  function automatic int word_off_w(input int xlen);
    return $clog2(xlen / 8);
  endfunction

  // Byte-offset width of a cacheline
  function automatic int blk_off_w(input int blk_bits);
    return $clog2(blk_bits / 8);
  endfunction

endpackage

// File: rtl/riscv_cache_fill_buffer.sv
// Line-fill buffer: counts incoming beats, places each beat at its wrapped
// word position starting from the critical word, and flags the last beat.
module riscv_cache_fill_buffer #(
  parameter int XLEN  = 32,
  parameter int BEATS = 8,
  parameter int IDX_W = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        start_i,
  input  logic [XLEN-1:0]         data_i,
  output logic [BEATS*XLEN-1:0]   line_o,
  output logic [XLEN-1:0]         word_o,
  output logic                    last_o
);

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] wr_idx;
  logic [XLEN-1:0]  line_q [BEATS];

  // Wrap index: the counter width equals log2(BEATS), so the sum wraps mod BEATS
  assign wr_idx = start_i + cnt_q;
  assign last_o = (cnt_q == IDX_W'(BEATS - 1));
  assign word_o = line_q[start_i];

  // Beat counter, restarted at the beginning of every burst
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (we_i)  cnt_q <= cnt_q + 1'b1;
  end

  // Line assembly: each data beat lands in its wrapped slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BEATS; i++) line_q[i] <= '0;
    end else if (we_i) begin
      line_q[wr_idx] <= data_i;
    end
  end

  // Flatten the buffer into the cacheline written back to memory
  always_comb begin
    line_o = '0;
    for (int i = 0; i < BEATS; i++) line_o[i*XLEN +: XLEN] = line_q[i];
  end

endmodule

// File: rtl/riscv_cache_hit.sv
// Cache hit stage: returns hit data directly, otherwise runs a critical-word-
// first wrapping line fill (or a single uncached read) on the BIU.
// Optional hit/miss counters are built when RV_CACHE_PERF_CNT_EN is defined.
module riscv_cache_hit
  import riscv_cache_pkg::*;
  import biu_constants_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PLEN     = XLEN,
  parameter int BLK_BITS = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                req_i,
  input  logic [PLEN-1:0]     adr_i,
  input  biu_size_t           size_i,
  input  logic                lock_i,
  input  biu_prot_t           prot_i,
  input  logic                is_cacheable_i,
  input  logic                is_misaligned_i,
  input  logic                hit_i,
  input  logic [BLK_BITS-1:0] line_i,
  output logic                stall_o,
  output logic                ack_o,
  output logic [XLEN-1:0]     q_o,
  output logic                err_o,
  output logic                biu_stb_o,
  input  logic                biu_stb_ack_i,
  input  logic                biu_d_ack_i,
  output logic [PLEN-1:0]     biu_adri_o,
  output biu_size_t           biu_size_o,
  output biu_type_t           biu_type_o,
  output logic                biu_lock_o,
  output biu_prot_t           biu_prot_o,
  input  logic [XLEN-1:0]     biu_q_i,
  input  logic                biu_err_i,
`ifdef RV_CACHE_PERF_CNT_EN
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o,
`endif
  output logic                fill_we_o,
  output logic [PLEN-1:0]     fill_adr_o,
  output logic [BLK_BITS-1:0] fill_line_o
);

  localparam int        BEATS     = cache_beats(BLK_BITS, XLEN);
  localparam int        WOFF      = word_off_w(XLEN);
  localparam int        BOFF      = blk_off_w(BLK_BITS);
  localparam int        IDX_W     = BOFF - WOFF;
  localparam biu_type_t WRAP_TYPE = biu_wrap_type(BEATS);

  cache_state_t     state_q;
  logic             err_q, flushed_q, fill_we_q;
  logic [IDX_W-1:0] start_q;
  logic             biu_stb_q, biu_lock_q;
  logic [PLEN-1:0]  biu_adri_q, fill_adr_q;
  biu_size_t        biu_size_q;
  biu_type_t        biu_type_q;
  biu_prot_t        biu_prot_q;

  logic             req_ok, hit_ack, miss_go, single_go, beat_we, last_beat;
  logic [XLEN-1:0]  hit_word, buf_word;

  assign req_ok    = (state_q == ST_ARMED) && req_i && !flush_i && !is_misaligned_i;
  assign hit_ack   = req_ok && is_cacheable_i && hit_i;
  assign miss_go   = req_ok && is_cacheable_i && !hit_i;
  assign single_go = req_ok && !is_cacheable_i;
  assign beat_we   = ((state_q == ST_FILL) || (state_q == ST_SINGLE)) && biu_d_ack_i;

  riscv_cache_fill_buffer #(
    .XLEN  (XLEN),
    .BEATS (BEATS),
    .IDX_W (IDX_W)
  ) u_fill_buffer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (miss_go | single_go),
    .we_i    (beat_we),
    .start_i (start_q),
    .data_i  (biu_q_i),
    .line_o  (fill_line_o),
    .word_o  (buf_word),
    .last_o  (last_beat)
  );

  // Select the addressed word out of the cacheline read on a hit
  always_comb begin
    hit_word = '0;
    for (int i = 0; i < BEATS; i++)
      if (adr_i[BOFF-1:WOFF] == IDX_W'(i)) hit_word = line_i[i*XLEN +: XLEN];
  end

  // Response path: same-cycle hit data, or buffered data in the recover cycle
  always_comb begin
    ack_o = 1'b0;
    err_o = 1'b0;
    q_o   = '0;
    if (hit_ack) begin
      ack_o = 1'b1;
      q_o   = hit_word;
    end else if (state_q == ST_RECOVER) begin
      ack_o = !err_q && !flushed_q;
      err_o = err_q && !flushed_q;
      q_o   = buf_word;
    end
  end

  assign stall_o = miss_go || single_go || (state_q == ST_FILL) || (state_q == ST_SINGLE);

  // Control FSM with registered BIU request and line write-back outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_ARMED;
      err_q      <= 1'b0;
      flushed_q  <= 1'b0;
      fill_we_q  <= 1'b0;
      fill_adr_q <= '0;
      start_q    <= '0;
      biu_stb_q  <= 1'b0;
      biu_adri_q <= '0;
      biu_size_q <= BYTE;
      biu_type_q <= SINGLE;
      biu_lock_q <= 1'b0;
      biu_prot_q <= '0;
    end else begin
      fill_we_q <= 1'b0;
      // The request strobe drops in the cycle after the BIU accepts it
      if (biu_stb_q && biu_stb_ack_i) biu_stb_q <= 1'b0;
      case (state_q)
        ST_ARMED: begin
          if (miss_go || single_go) begin
            state_q    <= miss_go ? ST_FILL : ST_SINGLE;
            biu_stb_q  <= 1'b1;
            biu_adri_q <= miss_go ? {adr_i[PLEN-1:WOFF], {WOFF{1'b0}}} : adr_i;
            biu_type_q <= miss_go ? WRAP_TYPE : SINGLE;
            biu_size_q <= miss_go ? WORD : size_i;
            biu_lock_q <= lock_i;
            biu_prot_q <= prot_i;
            start_q    <= adr_i[BOFF-1:WOFF];
            err_q      <= 1'b0;
            flushed_q  <= 1'b0;
          end
        end
        ST_FILL: begin
          if (flush_i) flushed_q <= 1'b1;
          if (biu_d_ack_i) begin
            if (biu_err_i) err_q <= 1'b1;
            if (last_beat) begin
              fill_we_q  <= !(err_q || biu_err_i);
              fill_adr_q <= {biu_adri_q[PLEN-1:BOFF], {BOFF{1'b0}}};
              state_q    <= ST_RECOVER;
            end
          end
        end
        ST_SINGLE: begin
          if (flush_i) flushed_q <= 1'b1;
          if (biu_d_ack_i) begin
            err_q   <= biu_err_i;
            state_q <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          err_q     <= 1'b0;
          flushed_q <= 1'b0;
          state_q   <= ST_ARMED;
        end
        default: state_q <= ST_ARMED;
      endcase
    end
  end

  assign biu_stb_o  = biu_stb_q;
  assign biu_adri_o = biu_adri_q;
  assign biu_size_o = biu_size_q;
  assign biu_type_o = biu_type_q;
  assign biu_lock_o = biu_lock_q;
  assign biu_prot_o = biu_prot_q;
  assign fill_we_o  = fill_we_q;
  assign fill_adr_o = fill_adr_q;

`ifdef RV_CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit and miss event counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_ack && (hit_cnt_q != 32'hFFFF_FFFF))  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_go && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_cache_hit.sv
// Bench for riscv_cache_hit: random hit, miss, uncached, error, flush and
// reset scenarios against a line-level memory model.
module tb_riscv_cache_hit;
  import biu_constants_pkg::*;

  logic          clk = 1'b0;
  logic          rst_ni, flush_i, req_i, lock_i, is_cacheable_i, is_misaligned_i, hit_i;
  logic [31:0]   adr_i;
  biu_size_t     size_i;
  biu_prot_t     prot_i;
  logic [255:0]  line_i;
  logic          stall_o, ack_o, err_o, biu_stb_o, biu_stb_ack_i, biu_d_ack_i;
  logic [31:0]   q_o, biu_adri_o, biu_q_i, fill_adr_o;
  biu_size_t     biu_size_o;
  biu_type_t     biu_type_o;
  logic          biu_lock_o, biu_err_i, fill_we_o;
  biu_prot_t     biu_prot_o;
  logic [255:0]  fill_line_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations collected while serving a burst
  logic [31:0]  seed_g;
  int           o_we_cnt, o_beats;
  logic         o_timeout, o_stall_ok, o_stb0, o_stb_after, o_ack, o_err, o_we_after, o_quiet_after;
  logic [31:0]  o_q, o_adri, o_fill_adr;
  logic [255:0] o_fill_line;
  biu_type_t    o_type;
  biu_size_t    o_size;
  logic         o_lock;
  biu_prot_t    o_prot;

  riscv_cache_hit dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .req_i(req_i), .adr_i(adr_i),
    .size_i(size_i), .lock_i(lock_i), .prot_i(prot_i), .is_cacheable_i(is_cacheable_i),
    .is_misaligned_i(is_misaligned_i), .hit_i(hit_i), .line_i(line_i), .stall_o(stall_o),
    .ack_o(ack_o), .q_o(q_o), .err_o(err_o), .biu_stb_o(biu_stb_o),
    .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i), .biu_adri_o(biu_adri_o),
    .biu_size_o(biu_size_o), .biu_type_o(biu_type_o), .biu_lock_o(biu_lock_o),
    .biu_prot_o(biu_prot_o), .biu_q_i(biu_q_i), .biu_err_i(biu_err_i),
    .fill_we_o(fill_we_o), .fill_adr_o(fill_adr_o), .fill_line_o(fill_line_o)
  );

  always #5 clk = ~clk;

  // Memory model: the content of every word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed_g;
  endfunction

  // Expected cacheline holding address a, word 0 in the low bits
  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  base;
    base = a & ~32'h1F;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_word(base + 32'(w * 4));
    return l;
  endfunction

  task automatic idle();
    req_i = 0; flush_i = 0; lock_i = 0; is_cacheable_i = 0; is_misaligned_i = 0; hit_i = 0;
    adr_i = 0; size_i = BYTE; prot_i = '0; line_i = '0;
    biu_stb_ack_i = 0; biu_d_ack_i = 0; biu_q_i = 0; biu_err_i = 0;
  endtask

  // BIU responder: starts at posedge+1 after the request was latched,
  // returns data for the wrapped beats, then records the recover cycle.
  task automatic serve(input logic [31:0] adr, input bit single, input logic [31:0] sdata,
                       input int err_beat, input int flush_beat, input int abort_at);
    int beat, cyc, nb, w;
    nb = single ? 1 : 8;
    beat = 0; cyc = 0; o_we_cnt = 0; o_stall_ok = 1; o_timeout = 0; o_stb_after = 0;
    o_stb0 = biu_stb_o; o_adri = biu_adri_o; o_type = biu_type_o; o_size = biu_size_o;
    o_lock = biu_lock_o; o_prot = biu_prot_o;
    while (beat < nb) begin
      if (beat == abort_at) begin o_beats = beat; return; end
      if (cyc > 200) begin o_timeout = 1; break; end
      biu_stb_ack_i = (cyc == 0);
      biu_d_ack_i   = (cyc == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
      w = ((adr >> 2) + beat) % 8;
      biu_q_i   = single ? sdata : mem_word((adr & ~32'h1F) + 32'(w * 4));
      biu_err_i = biu_d_ack_i && (beat == err_beat);
      flush_i   = (beat == flush_beat);
      @(negedge clk);
      if (!stall_o || ack_o || err_o) o_stall_ok = 0;
      if (fill_we_o) o_we_cnt++;
      if (cyc == 1) o_stb_after = biu_stb_o;
      @(posedge clk); #1;
      if (biu_d_ack_i) beat++;
      cyc++;
    end
    o_beats = beat;
    biu_stb_ack_i = 0; biu_d_ack_i = 0; biu_err_i = 0; flush_i = 0;
    @(negedge clk);
    if (fill_we_o) o_we_cnt++;
    o_fill_adr = fill_adr_o; o_fill_line = fill_line_o;
    o_ack = ack_o; o_err = err_o; o_q = q_o;
    @(posedge clk); #1;
    @(negedge clk);
    o_we_after = fill_we_o;
    o_quiet_after = !(ack_o || err_o || stall_o);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1; #2 rst_ni = 0; #3;
    n_checks++; if ({stall_o, ack_o, err_o, biu_stb_o, fill_we_o, biu_lock_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {stall_o, ack_o, err_o, biu_stb_o, fill_we_o, biu_lock_o}); end
    n_checks++; if ({q_o, biu_adri_o, fill_adr_o, 4'(biu_type_o), 3'(biu_size_o), biu_prot_o} !== '0) begin
      n_fail++; $display("FAIL reset_data: q=%h adri=%h fadr=%h want 0", q_o, biu_adri_o, fill_adr_o); end
    n_checks++; if (fill_line_o !== '0) begin
      n_fail++; $display("FAIL reset_line: got %h want 0", fill_line_o); end
    repeat (2) @(posedge clk); #1; rst_ni = 1;
    @(posedge clk); #1;
  endtask

  task automatic do_hit(input logic [31:0] adr, input logic [255:0] line, input string tag);
    logic [31:0] exp;
    exp = line[((adr >> 2) % 8) * 32 +: 32];
    req_i = 1; is_cacheable_i = 1; hit_i = 1; adr_i = adr; line_i = line; size_i = WORD;
    @(negedge clk);
    n_checks++; if ({ack_o, stall_o, err_o, q_o} !== {3'b100, exp}) begin
      n_fail++; $display("FAIL %s: ack/stall/err/q=%b%b%b/%h want 100/%h", tag, ack_o, stall_o, err_o, q_o, exp); end
    @(posedge clk); #1;
    req_i = 0; hit_i = 0;
    n_checks++; if (biu_stb_o !== 1'b0) begin
      n_fail++; $display("FAIL %s_stb: got %b want 0", tag, biu_stb_o); end
  endtask

  task automatic test_hit();
    logic [255:0] line;
    for (int i = 0; i < 8; i++) line[i*32 +: 32] = $urandom;
    line[63:32] = 32'hDEADBEEF;
    do_hit(32'h104, line, "hit_104");
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) line[i*32 +: 32] = $urandom;
      do_hit($urandom & ~32'h3, line, "hit_rand");
    end
    // A misaligned request is ignored entirely
    req_i = 1; is_cacheable_i = 1; hit_i = 0; is_misaligned_i = 1; adr_i = 32'h40;
    @(negedge clk);
    n_checks++; if ({ack_o, stall_o} !== 2'b00) begin
      n_fail++; $display("FAIL misaligned: ack/stall=%b%b want 00", ack_o, stall_o); end
    @(posedge clk); #1; idle();
    n_checks++; if (biu_stb_o !== 1'b0) begin
      n_fail++; $display("FAIL misaligned_stb: got %b want 0", biu_stb_o); end
  endtask

  // Issue a cacheable miss and serve it; checks shared by all fill scenarios
  task automatic do_miss(input logic [31:0] adr, input int err_beat, input int flush_beat, input string tag);
    seed_g = $urandom;
    req_i = 1; is_cacheable_i = 1; hit_i = 0; adr_i = adr; size_i = BYTE;
    lock_i = 1'($urandom); prot_i = biu_prot_t'($urandom);
    @(negedge clk);
    n_checks++; if ({stall_o, ack_o} !== 2'b10) begin
      n_fail++; $display("FAIL %s_stall: stall/ack=%b%b want 10", tag, stall_o, ack_o); end
    @(posedge clk); #1;
    req_i = 0;
    serve(adr, 0, 32'h0, err_beat, flush_beat, -1);
    n_checks++; if (o_timeout || o_beats != 8 || !o_stall_ok) begin
      n_fail++; $display("FAIL %s_burst: beats=%0d timeout=%b stall_held=%b want 8/0/1", tag, o_beats, o_timeout, o_stall_ok); end
    n_checks++; if ({o_stb0, o_stb_after, o_adri, o_type, o_size} !== {2'b10, adr & ~32'h3, WRAP8, WORD}) begin
      n_fail++; $display("FAIL %s_req: stb=%b%b adri=%h type=%0d size=%0d want 10/%h/%0d/%0d", tag,
                         o_stb0, o_stb_after, o_adri, o_type, o_size, adr & ~32'h3, WRAP8, WORD); end
  endtask

  task automatic test_miss();
    do_miss(32'h218, -1, -1, "miss_218");
    n_checks++; if ({o_we_cnt, o_fill_adr} !== {32'd1, 32'h200}) begin
      n_fail++; $display("FAIL miss_fill: we_cnt=%0d adr=%h want 1/00000200", o_we_cnt, o_fill_adr); end
    n_checks++; if (o_fill_line !== mem_line(32'h218)) begin
      n_fail++; $display("FAIL miss_line: got %h want %h", o_fill_line, mem_line(32'h218)); end
    n_checks++; if ({o_ack, o_err, o_q} !== {2'b10, mem_word(32'h218)}) begin
      n_fail++; $display("FAIL miss_ack: ack/err/q=%b%b/%h want 10/%h", o_ack, o_err, o_q, mem_word(32'h218)); end
    n_checks++; if (o_we_after || !o_quiet_after) begin
      n_fail++; $display("FAIL miss_after: we=%b quiet=%b want 0/1", o_we_after, o_quiet_after); end
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      a = $urandom & ~32'h3;
      do_miss(a, -1, -1, "miss_rand");
      n_checks++; if ({o_we_cnt, o_fill_adr, o_fill_line, o_ack, o_q} !== {32'd1, a & ~32'h1F, mem_line(a), 1'b1, mem_word(a)}) begin
        n_fail++; $display("FAIL miss_rand_data: adr=%h we=%0d fadr=%h ack=%b q=%h want 1/%h/1/%h", a, o_we_cnt, o_fill_adr, o_ack, o_q, a & ~32'h1F, mem_word(a)); end
    end
  endtask

  task automatic test_noncache();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a, d;
      biu_size_t   s;
      logic        l;
      biu_prot_t   p;
      a = (k == 0) ? 32'h8000_0000 : ($urandom & ~32'h3);
      d = (k == 0) ? 32'h1234 : $urandom;
      s = biu_size_t'($urandom_range(0, 2)); l = 1'($urandom); p = biu_prot_t'($urandom);
      req_i = 1; is_cacheable_i = 0; hit_i = 1'($urandom); adr_i = a; size_i = s; lock_i = l; prot_i = p;
      @(negedge clk);
      n_checks++; if ({stall_o, ack_o} !== 2'b10) begin
        n_fail++; $display("FAIL nc_stall: stall/ack=%b%b want 10", stall_o, ack_o); end
      @(posedge clk); #1;
      idle();
      serve(a, 1, d, -1, -1, -1);
      n_checks++; if ({o_stb0, o_adri, o_type, o_size, o_lock, o_prot} !== {1'b1, a, SINGLE, s, l, p}) begin
        n_fail++; $display("FAIL nc_req: stb=%b adri=%h type=%0d size=%0d lock=%b prot=%0d want 1/%h/%0d/%0d/%b/%0d",
                           o_stb0, o_adri, o_type, o_size, o_lock, o_prot, a, SINGLE, s, l, p); end
      n_checks++; if ({o_ack, o_err, o_q, o_we_cnt} !== {2'b10, d, 32'd0} || o_timeout) begin
        n_fail++; $display("FAIL nc_ack: ack/err/q/we=%b%b/%h/%0d want 10/%h/0", o_ack, o_err, o_q, o_we_cnt, d); end
    end
  endtask

  task automatic test_error();
    do_miss(32'h0000_3A4C, 3, -1, "err");
    n_checks++; if ({o_we_cnt, o_ack, o_err} !== {32'd0, 2'b01}) begin
      n_fail++; $display("FAIL err_resp: we_cnt=%0d ack=%b err=%b want 0/0/1", o_we_cnt, o_ack, o_err); end
    // The error flag must not leak into the next fill
    do_miss(32'h0000_3A50, -1, -1, "err_next");
    n_checks++; if ({o_we_cnt, o_ack, o_err} !== {32'd1, 2'b10}) begin
      n_fail++; $display("FAIL err_clear: we_cnt=%0d ack=%b err=%b want 1/1/0", o_we_cnt, o_ack, o_err); end
  endtask

  task automatic test_flush();
    do_miss(32'h0001_0074, -1, 2, "flush");
    n_checks++; if ({o_we_cnt, o_fill_adr, o_ack, o_err} !== {32'd1, 32'h0001_0060, 2'b00}) begin
      n_fail++; $display("FAIL flush_resp: we_cnt=%0d fadr=%h ack=%b err=%b want 1/00010060/0/0", o_we_cnt, o_fill_adr, o_ack, o_err); end
    n_checks++; if (o_fill_line !== mem_line(32'h0001_0074)) begin
      n_fail++; $display("FAIL flush_line: got %h want %h", o_fill_line, mem_line(32'h0001_0074)); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] line;
    int we_seen;
    seed_g = $urandom;
    req_i = 1; is_cacheable_i = 1; hit_i = 0; adr_i = 32'h0000_0C08;
    @(posedge clk); #1;
    req_i = 0;
    serve(32'h0000_0C08, 0, 32'h0, -1, -1, 4);
    idle();
    rst_ni = 0; #2;
    n_checks++; if ({stall_o, ack_o, err_o, biu_stb_o, fill_we_o, fill_adr_o, biu_adri_o} !== '0 || fill_line_o !== '0) begin
      n_fail++; $display("FAIL rstmid_outs: stall=%b stb=%b we=%b adri=%h want all 0", stall_o, biu_stb_o, fill_we_o, biu_adri_o); end
    @(posedge clk); #1; rst_ni = 1;
    we_seen = 0;
    for (int i = 0; i < 4; i++) begin
      biu_d_ack_i = 1'($urandom);
      @(negedge clk);
      if (fill_we_o || stall_o) we_seen++;
      @(posedge clk); #1;
    end
    biu_d_ack_i = 0;
    n_checks++; if (we_seen != 0) begin
      n_fail++; $display("FAIL rstmid_armed: active cycles=%0d want 0", we_seen); end
    for (int i = 0; i < 8; i++) line[i*32 +: 32] = $urandom;
    do_hit(32'h0000_0C1C, line, "rstmid_hit");
  endtask

  task automatic test_back_to_back();
    logic [255:0] line;
    for (int i = 0; i < 8; i++) line[i*32 +: 32] = $urandom;
    do_hit(32'h500, line, "b2b_hit0");
    do_miss(32'h0000_5004, -1, -1, "b2b_miss");
    n_checks++; if ({o_ack, o_q} !== {1'b1, mem_word(32'h0000_5004)}) begin
      n_fail++; $display("FAIL b2b_miss_q: ack=%b q=%h want 1/%h", o_ack, o_q, mem_word(32'h0000_5004)); end
    do_hit(32'h51C, line, "b2b_hit1");
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_hit();
    test_miss();
    test_noncache();
    test_error();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_cache_hit.md
Name: riscv_cache_hit

Overview:
- Stage directly downstream of the cache tag stage.
- Consumes the delayed request (req/adr/size/lock/prot/cacheable/misaligned) together with the tag-compare hit and cacheline read from the cache memory.
- On a hit it returns the addressed word. On a miss it runs a wrapping BIU line-fill burst, writes the line back to cache memory, then returns the word. Non-cacheable accesses issue a single BIU read.

Parameters:
XLEN, 32, data word width
PLEN, XLEN, physical address width
BLK_BITS, 256, cacheline width; BEATS = BLK_BITS/XLEN (power of 2, 2..16)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush
req_i  in  1  request valid from tag stage
adr_i  in  PLEN  request address
size_i  in  biu_size_t  access size
lock_i  in  1  locked access
prot_i  in  biu_prot_t  protection
is_cacheable_i  in  1  region cacheable
is_misaligned_i  in  1  access misaligned
hit_i  in  1  tag match, valid with req_i
line_i  in  BLK_BITS  cacheline from memory stage
stall_o  out  1  stalls upstream stages
ack_o  out  1  one-cycle data-valid strobe
q_o  out  XLEN  read data
err_o  out  1  one-cycle bus-error strobe
biu_stb_o  out  1  BIU request
biu_stb_ack_i  in  1  BIU accepted request
biu_d_ack_i  in  1  BIU data beat valid
biu_adri_o  out  PLEN  BIU start address
biu_size_o  out  biu_size_t  BIU size
biu_type_o  out  biu_type_t  SINGLE or WRAP<BEATS>
biu_lock_o  out  1  BIU lock
biu_prot_o  out  biu_prot_t  BIU protection
biu_q_i  in  XLEN  BIU read data
biu_err_i  in  1  BIU error, valid with biu_d_ack_i
fill_we_o  out  1  one-cycle line write strobe
fill_adr_o  out  PLEN  line-aligned fill address
fill_line_o  out  BLK_BITS  fill data

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i. On reset the state is ARMED, and all outputs, the beat counter and the error flag are 0.
- States: ARMED, FILL, SINGLE, RECOVER.
- ARMED:
  - When req_i and !flush_i:
    - is_misaligned_i: no action.
    - Cacheable hit: combinational ack_o=1; q_o = line_i word selected by adr_i[log2(BLK_BITS/8)-1:log2(XLEN/8)]; no stall.
    - Cacheable miss: stall_o=1; go FILL. Drive biu_stb_o=1, biu_adri_o = word-aligned adr_i (critical word first), biu_type_o = WRAP<BEATS>, biu_size_o = WORD.
    - Non-cacheable: stall_o=1; go SINGLE with biu_type_o=SINGLE and size/lock/prot taken from the request.
  - All BIU request fields are registered at entry to FILL or SINGLE.
- biu_stb_o holds until the cycle after biu_stb_ack_i, then drops. biu_stb_ack_i and biu_d_ack_i may both arrive in the same cycle.
- FILL:
  - Each biu_d_ack_i writes biu_q_i into buffer slot (start_word + cnt) mod BEATS; cnt increments.
  - biu_err_i sets a sticky error flag.
  - On beat BEATS-1: if no error, pulse fill_we_o with fill_adr_o = line-aligned address. Then go RECOVER.
- SINGLE: on biu_d_ack_i, capture biu_q_i and biu_err_i; go RECOVER.
- RECOVER (1 cycle):
  - ack_o = !error && !flushed; err_o = error && !flushed.
  - q_o = the requested word from the buffer.
  - Clear the error and flushed flags; stall_o=0; return to ARMED.
- stall_o = 1 in FILL and SINGLE, and in ARMED on a miss or non-cacheable request.
- flush_i in FILL/SINGLE: the burst always completes. The flushed flag suppresses ack_o/err_o, but fill_we_o still fires on an error-free fill.
- Reset mid-burst: immediate return to ARMED; no fill_we_o.

Optional Feature:
- RV_CACHE_PERF_CNT_EN defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Reset value 0.
  - hit_cnt_o increments on a cacheable hit ack; miss_cnt_o increments on entry to FILL.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent.

Decomposition:
- riscv_cache_pkg: state enum, BEATS/offset-width helper functions.
- biu_constants_pkg: biu_size_t, biu_type_t, biu_prot_t and the WRAP encodings.
- Sub-module riscv_cache_fill_buffer: beat counter, wrap index, line assembly and last-beat flag.

Test Plan:
- Hit: req, hit_i=1, adr=0x104, line word1=0xDEADBEEF -> same-cycle ack_o=1, q_o=0xDEADBEEF, stall_o=0, no biu_stb_o.
- Miss, critical word first: adr=0x218 (BLK 256) -> biu_adri_o=0x218, WRAP8. Beats order words 6,7,0..5 -> fill_we_o once with fill_adr_o=0x200 and the line correctly ordered; ack_o next cycle with q_o = word 6 data.
- Non-cacheable: adr=0x8000_0000 -> SINGLE; d_ack data 0x1234 -> ack_o, q_o=0x1234.
- Error: biu_err_i on beat 3 of 8 -> all 8 beats consumed, no fill_we_o, err_o=1 and no ack_o.
- Flush mid-fill: flush_i in beat 2 -> fill completes, fill_we_o=1, ack_o=0.
- Reset mid-FILL: rst_ni low at beat 4 -> all outputs 0, state ARMED; next hit acked normally.
